// File: rtl/muldiv_unit_pkg.sv
// Shared op-code constants, FSM encoding and decode helpers for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned ITERS = 32;

    function automatic logic a_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional 32-bit two's-complement negate used for operand magnitudes and result signs.
module muldiv_negate (
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = en ? (~din + 32'd1) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring divide on magnitudes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero,
    input  logic            flush
);
    state_e      state_q, state_n;
    op_e         op_q;
    logic [31:0] hi_q, lo_q, b_q, res_q;
    logic [5:0]  cnt_q;
    logic        neg_q, neg_r, special_q;

    op_e         op_in;
    logic        a_sgn, b_sgn, div_zero, div_ovf, accept;
    logic [31:0] a_mag, b_mag, special_res;

    assign op_in    = op_e'(req_op);
    assign a_sgn    = req_a[31] & a_signed(op_in);
    assign b_sgn    = req_b[31] & b_signed(op_in);
    assign div_zero = op_in[2] && (req_b == 32'd0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    assign accept   = (state_q == ST_IDLE) && req_valid && !flush;

    // op[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = op_in[1] ? req_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = op_in[1] ? 32'd0 : 32'h8000_0000;
    end

    muldiv_negate u_neg_a (.en(a_sgn), .din(req_a), .dout(a_mag));
    muldiv_negate u_neg_b (.en(b_sgn), .din(req_b), .dout(b_mag));

    // One-bit steps: hi/lo hold product halves or remainder/quotient.
    logic [32:0] mul_sum, div_rs, div_diff;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_rs   = {hi_q, lo_q[31]};
    assign div_diff = div_rs - {1'b0, b_q};

    logic        is_div, is_rem, res_en;
    logic [31:0] res_sel, res_neg, final_res;
    assign is_div  = op_q[2];
    assign is_rem  = op_q[1];
    assign res_sel = is_div ? (is_rem ? hi_q : lo_q) : ((op_q == OP_MUL) ? lo_q : hi_q);
    assign res_en  = is_div ? (is_rem ? neg_r : neg_q) : ((op_q != OP_MUL) && neg_q);

    muldiv_negate u_neg_res (.en(res_en), .din(res_sel), .dout(res_neg));

    // High half of a negated 64-bit product only takes the +1 carry when the low half is zero.
    assign final_res = (!is_div && res_en && (lo_q != 32'd0)) ? ~hi_q : res_neg;

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_n = ST_CALC;
            ST_CALC: if (special_q || (cnt_q == 6'(ITERS))) state_n = ST_DONE;
            ST_DONE: if (resp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                op_q      <= op_in;
                hi_q      <= '0;
                lo_q      <= a_mag;
                b_q       <= b_mag;
                cnt_q     <= '0;
                neg_q     <= a_sgn ^ b_sgn;
                neg_r     <= a_sgn;
                special_q <= div_zero || div_ovf;
                res_q     <= special_res;
            end else if (state_q == ST_CALC && !special_q && !flush) begin
                if (cnt_q != 6'(ITERS)) begin
                    cnt_q <= cnt_q + 6'd1;
                    if (is_div) begin
                        if (!div_diff[32]) begin
                            hi_q <= div_diff[31:0];
                            lo_q <= {lo_q[30:0], 1'b1};
                        end else begin
                            hi_q <= div_rs[31:0];
                            lo_q <= {lo_q[30:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[32:1];
                        lo_q <= {mul_sum[0], lo_q[31:1]};
                    end
                end else begin
                    res_q <= final_res;
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_valid ? res_q : '0;
    assign resp_zero  = (resp_data == '0);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  datapath presents an operation.
REQ-005 Port: req_ready  output  1  unit can accept an operation.
REQ-006 Port: req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port: req_a  input  32  rs1 operand (multiplicand/dividend).
REQ-008 Port: req_b  input  32  rs2 operand (multiplier/divisor).
REQ-009 Port: resp_valid  output  1  result available.
REQ-010 Port: resp_ready  input  1  datapath consumes the result.
REQ-011 Port: resp_data  output  32  result.
REQ-012 Port: resp_zero  output  1  high when resp_data == 0.
REQ-013 Port: flush  input  1  synchronous abort of any operation in flight.

Function
REQ-014 The unit SHALL have three states: IDLE, CALC, DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-016 On acceptance the unit SHALL latch op, operands, and operand signs; inputs may then change freely.
REQ-017 IDLE->CALC on acceptance; CALC runs exactly 32 iterations (one bit per cycle, shift-add for MUL*, restoring divide for DIV*/REM*), then CALC->DONE.
REQ-018 Latency: accepted on edge k -> resp_valid high after edge k+33.
REQ-019 Divide by zero: accepted on edge k -> DONE after edge k+1; DIV/DIVU result 0xFFFFFFFF; REM/REMU result = req_a.
REQ-020 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DONE after edge k+1; DIV result 0x80000000; REM result 0.
REQ-021 Signed ops SHALL operate on magnitudes, then negate: quotient if signs differ, remainder follows dividend sign; MULH sign = a31^b31, MULHSU treats b as unsigned.
REQ-022 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-023 In DONE, resp_valid=1 and resp_data/resp_zero SHALL be stable until resp_valid && resp_ready; then DONE->IDLE on that edge.
REQ-024 Back-to-back: the next request SHALL be acceptable no earlier than the cycle after the response handshake (no overlap).
REQ-025 flush=1 SHALL force IDLE on the next edge from any state and discard the result; flush has priority over acceptance and response handshake on the same edge.
REQ-026 resp_data SHALL be 0 and resp_valid 0 whenever not in DONE.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, req_ready=1 after release, resp_valid=0, resp_data=0, resp_zero=1, and clear all datapath registers.
REQ-028 Reset mid-CALC SHALL abandon the operation; no response is produced for it.

Structure
REQ-029 A shared package SHALL hold the op-code constants (MUL..REMU) and state encoding; the ALU control decode SHALL use the same op constants.
REQ-030 One sub-module, muldiv_negate (conditional 32-bit two's-complement negate), SHALL be instantiated for operand and result sign handling.

Verification
REQ-031 MUL a=7, b=0xFFFFFFFD (-3) -> resp_data 0xFFFFFFEB after 33 cycles, resp_zero=0.
REQ-032 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000, resp_zero=1.
REQ-033 DIV a=-7, b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14.
REQ-034 DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle; DIV a=0x80000000, b=-1 -> 0x80000000; REM same -> 0.
REQ-035 resp_ready held 0 for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready=0 throughout.
REQ-036 flush at CALC cycle 10, and rst_n low at CALC cycle 20 on a second op -> IDLE, no resp_valid; the next MULHU 3x5 returns 0.
